// File: rtl/rename_map_table.sv
// Speculative register-rename map: translates WAYS sources/destinations per cycle with
// in-group RAW/WAW bypass, snapshots the map per branch and restores it on a mispredict.
module rename_map_table #(
    parameter int ARCH_REGS = 32,
    parameter int PHY_REGS  = 64,
    parameter int WAYS      = 2,
    parameter int CKPTS     = 4,
    localparam int AW       = $clog2(ARCH_REGS),
    localparam int PW       = $clog2(PHY_REGS),
    localparam int TW       = $clog2(CKPTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WAYS-1:0]    rn_valid,
    input  logic [WAYS*AW-1:0] rs1_arch,
    input  logic [WAYS*AW-1:0] rs2_arch,
    input  logic [WAYS*AW-1:0] dst_arch,
    input  logic [WAYS-1:0]    dst_we,
    input  logic [WAYS*PW-1:0] phy_dst,
    input  logic [WAYS-1:0]    br_mask,
    input  logic               commit_br,
    input  logic               prmiss,
    input  logic [TW-1:0]      prmiss_tag,
    output logic [WAYS*PW-1:0] rs1_phy,
    output logic [WAYS*PW-1:0] rs2_phy,
    output logic [WAYS*PW-1:0] old_dst_phy,
    output logic [TW-1:0]      ckpt_tag,
    output logic               rn_stall,
    output logic               ckpt_full,
    output logic [TW:0]        ckpt_count
);

    localparam logic [TW:0] FULL_COUNT = (TW+1)'(CKPTS);

    logic [PW-1:0] map      [ARCH_REGS];
    logic [PW-1:0] ckpt_map [CKPTS][ARCH_REGS];
    logic [TW-1:0] head;
    logic [TW-1:0] tail;
    logic [TW:0]   count;

    logic [AW-1:0] rs1_a [WAYS];
    logic [AW-1:0] rs2_a [WAYS];
    logic [AW-1:0] dst_a [WAYS];
    logic [PW-1:0] phy_a [WAYS];
    logic [PW-1:0] rs1_t [WAYS];
    logic [PW-1:0] rs2_t [WAYS];
    logic [PW-1:0] old_t [WAYS];

    logic [PW-1:0] next_map [ARCH_REGS];
    logic [PW-1:0] snap_map [ARCH_REGS];
    logic [WAYS-1:0] we_eff;
    logic            has_br;
    logic            accept;
    logic            alloc;
    logic            commit_ok;

    logic [TW-1:0] restore_diff;
    logic [TW-1:0] restore_off;
    logic          restore_live;
    logic [TW:0]   restore_count;

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            rs1_a[i] = rs1_arch[i*AW +: AW];
            rs2_a[i] = rs2_arch[i*AW +: AW];
            dst_a[i] = dst_arch[i*AW +: AW];
            phy_a[i] = phy_dst[i*PW +: PW];
        end
    end

    assign ckpt_full  = (count == FULL_COUNT);
    assign ckpt_count = count;
    assign ckpt_tag   = tail;
    assign has_br     = |(br_mask & rn_valid);
    assign rn_stall   = ckpt_full & has_br & ~prmiss;
    assign accept     = ~prmiss & ~rn_stall;
    assign alloc      = accept & has_br;
    assign commit_ok  = commit_br & (count != '0);

    // Older slots in the group override the map; the youngest matching older slot wins.
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            rs1_t[i] = map[rs1_a[i]];
            rs2_t[i] = map[rs2_a[i]];
            old_t[i] = map[dst_a[i]];
            for (int j = 0; j < WAYS; j++) begin
                if (j < i && rn_valid[j] && dst_we[j]) begin
                    if (dst_a[j] == rs1_a[i]) rs1_t[i] = phy_a[j];
                    if (dst_a[j] == rs2_a[i]) rs2_t[i] = phy_a[j];
                    if (dst_a[j] == dst_a[i]) old_t[i] = phy_a[j];
                end
            end
            if (rs1_a[i] == '0) rs1_t[i] = '0;
            if (rs2_a[i] == '0) rs2_t[i] = '0;
            if (dst_a[i] == '0) old_t[i] = '0;
        end
    end

    always_comb begin
        rs1_phy     = '0;
        rs2_phy     = '0;
        old_dst_phy = '0;
        for (int i = 0; i < WAYS; i++) begin
            rs1_phy[i*PW +: PW]     = rs1_t[i];
            rs2_phy[i*PW +: PW]     = rs2_t[i];
            old_dst_phy[i*PW +: PW] = old_t[i];
        end
    end

    // Writes apply in slot order; the snapshot freezes right after the branch slot's write.
    always_comb begin
        next_map = map;
        snap_map = map;
        we_eff   = '0;
        for (int i = 0; i < WAYS; i++) begin
            we_eff[i] = rn_valid[i] & dst_we[i] & (dst_a[i] != '0) & accept;
            if (we_eff[i]) next_map[dst_a[i]] = phy_a[i];
            if (br_mask[i] && rn_valid[i]) snap_map = next_map;
        end
    end

    // A restored entry that wraps to zero distance is the whole buffer, not empty.
    always_comb begin
        restore_diff  = prmiss_tag + TW'(1) - head;
        restore_off   = prmiss_tag - head;
        restore_live  = ({1'b0, restore_off} < count);
        restore_count = (restore_diff == '0 && restore_live) ? FULL_COUNT : {1'b0, restore_diff};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) map[i] <= PW'(i);
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (prmiss) begin
            map  <= ckpt_map[prmiss_tag];
            tail <= prmiss_tag + TW'(1);
            if (commit_ok && restore_count != '0) begin
                head  <= head + TW'(1);
                count <= restore_count - (TW+1)'(1);
            end else begin
                count <= restore_count;
            end
        end else begin
            map <= next_map;
            if (alloc) tail <= tail + TW'(1);
            if (commit_ok) head <= head + TW'(1);
            case ({alloc, commit_ok})
                2'b10:   count <= count + (TW+1)'(1);
                2'b01:   count <= count - (TW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && alloc) ckpt_map[tail] <= snap_map;
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table: bypass, zero register, checkpoint fill/stall,
// misprediction restore with concurrent commit, and mid-stream reset.
module tb_rename_map_table;

    localparam int ARCH_REGS = 32;
    localparam int PHY_REGS  = 64;
    localparam int WAYS      = 2;
    localparam int CKPTS     = 4;
    localparam int AW        = 5;
    localparam int PW        = 6;
    localparam int TW        = 2;

    logic               clk;
    logic               reset;
    logic [WAYS-1:0]    rn_valid;
    logic [WAYS*AW-1:0] rs1_arch;
    logic [WAYS*AW-1:0] rs2_arch;
    logic [WAYS*AW-1:0] dst_arch;
    logic [WAYS-1:0]    dst_we;
    logic [WAYS*PW-1:0] phy_dst;
    logic [WAYS-1:0]    br_mask;
    logic               commit_br;
    logic               prmiss;
    logic [TW-1:0]      prmiss_tag;
    logic [WAYS*PW-1:0] rs1_phy;
    logic [WAYS*PW-1:0] rs2_phy;
    logic [WAYS*PW-1:0] old_dst_phy;
    logic [TW-1:0]      ckpt_tag;
    logic               rn_stall;
    logic               ckpt_full;
    logic [TW:0]        ckpt_count;

    int errors = 0;
    int checks = 0;

    rename_map_table #(
        .ARCH_REGS(ARCH_REGS),
        .PHY_REGS (PHY_REGS),
        .WAYS     (WAYS),
        .CKPTS    (CKPTS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rn_valid   (rn_valid),
        .rs1_arch   (rs1_arch),
        .rs2_arch   (rs2_arch),
        .dst_arch   (dst_arch),
        .dst_we     (dst_we),
        .phy_dst    (phy_dst),
        .br_mask    (br_mask),
        .commit_br  (commit_br),
        .prmiss     (prmiss),
        .prmiss_tag (prmiss_tag),
        .rs1_phy    (rs1_phy),
        .rs2_phy    (rs2_phy),
        .old_dst_phy(old_dst_phy),
        .ckpt_tag   (ckpt_tag),
        .rn_stall   (rn_stall),
        .ckpt_full  (ckpt_full),
        .ckpt_count (ckpt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] slot_of(input logic [WAYS*PW-1:0] v, input int s);
        return 32'(v[s*PW +: PW]);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clear_inputs();
        rn_valid   = '0;
        rs1_arch   = '0;
        rs2_arch   = '0;
        dst_arch   = '0;
        dst_we     = '0;
        phy_dst    = '0;
        br_mask    = '0;
        commit_br  = 1'b0;
        prmiss     = 1'b0;
        prmiss_tag = '0;
    endtask

    task automatic apply_stimulus(input int slot, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                  input logic [AW-1:0] dst, input logic we, input logic [PW-1:0] phy,
                                  input logic br);
        rn_valid[slot]            = 1'b1;
        rs1_arch[slot*AW +: AW]   = rs1;
        rs2_arch[slot*AW +: AW]   = rs2;
        dst_arch[slot*AW +: AW]   = dst;
        dst_we[slot]              = we;
        phy_dst[slot*PW +: PW]    = phy;
        br_mask[slot]             = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Identity map out of reset; commit with no live checkpoint
        apply_stimulus(0, 5'd5, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0);
        commit_br = 1'b1;
        settle();
        check_output("rst_rs1", slot_of(rs1_phy, 0), 32'd5);
        check_output("rst_rs2", slot_of(rs2_phy, 0), 32'd0);
        check_output("rst_count", 32'(ckpt_count), 32'd0);
        check_output("rst_full", 32'(ckpt_full), 32'd0);
        check_output("rst_tag", 32'(ckpt_tag), 32'd0);
        check_output("rst_stall", 32'(rn_stall), 32'd0);
        tick();

        // WAW on x3 within one group with RAW bypass to slot1
        clear_inputs();
        apply_stimulus(0, 5'd3, 5'd0, 5'd3, 1'b1, 6'd40, 1'b0);
        apply_stimulus(1, 5'd3, 5'd0, 5'd3, 1'b1, 6'd41, 1'b0);
        settle();
        check_output("empty_commit_count", 32'(ckpt_count), 32'd0);
        check_output("raw_s0_rs1", slot_of(rs1_phy, 0), 32'd3);
        check_output("raw_s1_rs1", slot_of(rs1_phy, 1), 32'd40);
        check_output("waw_s0_old", slot_of(old_dst_phy, 0), 32'd3);
        check_output("waw_s1_old", slot_of(old_dst_phy, 1), 32'd40);
        tick();

        // Youngest write wins; writes to x0 are dropped and never bypass
        clear_inputs();
        apply_stimulus(0, 5'd3, 5'd0, 5'd0, 1'b1, 6'd55, 1'b0);
        apply_stimulus(1, 5'd0, 5'd3, 5'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_output("waw_x3", slot_of(rs1_phy, 0), 32'd41);
        check_output("x0_bypass", slot_of(rs1_phy, 1), 32'd0);
        check_output("s1_rs2_x3", slot_of(rs2_phy, 1), 32'd41);
        tick();

        // Branch in slot0 writes x4->50, slot1 x4->51 stays out of the checkpoint
        clear_inputs();
        apply_stimulus(0, 5'd0, 5'd0, 5'd4, 1'b1, 6'd50, 1'b1);
        apply_stimulus(1, 5'd0, 5'd4, 5'd4, 1'b1, 6'd51, 1'b0);
        settle();
        check_output("x0_after_write", slot_of(rs1_phy, 0), 32'd0);
        check_output("br0_tag", 32'(ckpt_tag), 32'd0);
        check_output("br0_s1_rs2", slot_of(rs2_phy, 1), 32'd50);
        tick();

        clear_inputs();
        apply_stimulus(0, 5'd4, 5'd0, 5'd4, 1'b1, 6'd52, 1'b0);
        settle();
        check_output("x4_after_br", slot_of(rs1_phy, 0), 32'd51);
        check_output("count_1", 32'(ckpt_count), 32'd1);
        tick();

        clear_inputs();
        apply_stimulus(0, 5'd4, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0);
        prmiss     = 1'b1;
        prmiss_tag = 2'd0;
        settle();
        check_output("x4_before_miss", slot_of(rs1_phy, 0), 32'd52);
        tick();

        // Restored map; then fill remaining checkpoints (tags 1..3)
        clear_inputs();
        apply_stimulus(0, 5'd4, 5'd3, 5'd10, 1'b1, 6'd30, 1'b1);
        apply_stimulus(1, 5'd0, 5'd0, 5'd10, 1'b1, 6'd31, 1'b0);
        settle();
        check_output("restored_x4", slot_of(rs1_phy, 0), 32'd50);
        check_output("restored_x3", slot_of(rs2_phy, 0), 32'd41);
        check_output("restored_count", 32'(ckpt_count), 32'd1);
        check_output("br1_tag", 32'(ckpt_tag), 32'd1);
        tick();

        clear_inputs();
        apply_stimulus(0, 5'd0, 5'd0, 5'd12, 1'b1, 6'd32, 1'b0);
        apply_stimulus(1, 5'd0, 5'd0, 5'd12, 1'b1, 6'd33, 1'b1);
        settle();
        check_output("br2_tag", 32'(ckpt_tag), 32'd2);
        check_output("count_2", 32'(ckpt_count), 32'd2);
        tick();

        clear_inputs();
        apply_stimulus(0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 1'b1);
        settle();
        check_output("br3_tag", 32'(ckpt_tag), 32'd3);
        check_output("count_3", 32'(ckpt_count), 32'd3);
        check_output("not_full_3", 32'(ckpt_full), 32'd0);
        tick();

        // Fifth branch stalls against a full buffer
        clear_inputs();
        apply_stimulus(0, 5'd0, 5'd0, 5'd11, 1'b1, 6'd45, 1'b1);
        settle();
        check_output("full_4", 32'(ckpt_full), 32'd1);
        check_output("count_4", 32'(ckpt_count), 32'd4);
        check_output("stall_full", 32'(rn_stall), 32'd1);
        check_output("stall_tag", 32'(ckpt_tag), 32'd0);
        tick();

        clear_inputs();
        apply_stimulus(0, 5'd11, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0);
        commit_br = 1'b1;
        settle();
        check_output("stall_no_write", slot_of(rs1_phy, 0), 32'd11);
        check_output("full_during_commit", 32'(ckpt_full), 32'd1);
        tick();

        clear_inputs();
        apply_stimulus(0, 5'd0, 5'd0, 5'd11, 1'b1, 6'd45, 1'b1);
        settle();
        check_output("full_cleared", 32'(ckpt_full), 32'd0);
        check_output("count_after_commit", 32'(ckpt_count), 32'd3);
        check_output("retry_stall", 32'(rn_stall), 32'd0);
        check_output("retry_tag_wrap", 32'(ckpt_tag), 32'd0);
        tick();

        // prmiss to tag 2 with a concurrent rename group and commit_br
        clear_inputs();
        apply_stimulus(0, 5'd11, 5'd0, 5'd7, 1'b1, 6'd60, 1'b1);
        prmiss     = 1'b1;
        prmiss_tag = 2'd2;
        commit_br  = 1'b1;
        settle();
        check_output("miss_no_stall", 32'(rn_stall), 32'd0);
        check_output("miss_full", 32'(ckpt_full), 32'd1);
        check_output("retry_x11", slot_of(rs1_phy, 0), 32'd45);
        tick();

        clear_inputs();
        apply_stimulus(0, 5'd7, 5'd12, 5'd0, 1'b0, 6'd0, 1'b0);
        apply_stimulus(1, 5'd10, 5'd11, 5'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_output("miss_x7_dropped", slot_of(rs1_phy, 0), 32'd7);
        check_output("ck2_x12", slot_of(rs2_phy, 0), 32'd33);
        check_output("ck2_x10", slot_of(rs1_phy, 1), 32'd31);
        check_output("ck2_x11", slot_of(rs2_phy, 1), 32'd11);
        check_output("miss_commit_count", 32'(ckpt_count), 32'd1);
        check_output("miss_tail", 32'(ckpt_tag), 32'd3);
        tick();

        // Refill to full (tags 3,0,1), then restore the youngest entry
        clear_inputs();
        apply_stimulus(0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 1'b1);
        settle();
        check_output("refill_tag3", 32'(ckpt_tag), 32'd3);
        tick();
        settle();
        check_output("refill_tag0", 32'(ckpt_tag), 32'd0);
        tick();
        settle();
        check_output("refill_tag1", 32'(ckpt_tag), 32'd1);
        tick();

        clear_inputs();
        prmiss     = 1'b1;
        prmiss_tag = 2'd1;
        settle();
        check_output("refill_full", 32'(ckpt_full), 32'd1);
        tick();

        clear_inputs();
        apply_stimulus(0, 5'd10, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_output("wrap_restore_count", 32'(ckpt_count), 32'd4);
        check_output("wrap_restore_full", 32'(ckpt_full), 32'd1);
        check_output("wrap_restore_tail", 32'(ckpt_tag), 32'd2);
        check_output("wrap_restore_x10", slot_of(rs1_phy, 0), 32'd31);

        // Reset mid-stream with live checkpoints
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_inputs();
        apply_stimulus(0, 5'd10, 5'd3, 5'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_output("mid_rst_x10", slot_of(rs1_phy, 0), 32'd10);
        check_output("mid_rst_x3", slot_of(rs2_phy, 0), 32'd3);
        check_output("mid_rst_count", 32'(ckpt_count), 32'd0);
        check_output("mid_rst_full", 32'(ckpt_full), 32'd0);
        check_output("mid_rst_tag", 32'(ckpt_tag), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
